// File: rtl/fsm_table_ctrl_pkg.sv
// Shared types and layout constants for the table-driven FSM controller.
package fsm_table_ctrl_pkg;

  // Default geometry: 2-bit input symbol, 3-bit state/output.
  localparam int unsigned DEF_IN_W = 2;
  localparam int unsigned DEF_ST_W = 3;

  // Controller states; encodings are externally documented and must not move.
  typedef enum logic [1:0] {
    CT_IDLE = 2'd0,
    CT_LOAD = 2'd1,
    CT_RUN  = 2'd2,
    CT_HALT = 2'd3
  } ctrl_e;

  // Entry layout for the default geometry: {next_state, out}.
  localparam int unsigned ENTRY_NEXT_MSB = 5;
  localparam int unsigned ENTRY_NEXT_LSB = 3;
  localparam int unsigned ENTRY_OUT_MSB  = 2;
  localparam int unsigned ENTRY_OUT_LSB  = 0;

endpackage

// File: rtl/fsm_table_ctrl_ram.sv
// Transition table: sync write, async read, plus per-entry valid mask.
module fsm_table_ram #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          full
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0]    mem [Depth];
  logic [Depth-1:0] mask_q;

  // Table storage is deliberately not reset; the mask tracks what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Valid mask: one bit per written entry, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  mask_q <= '0;
    else if (we) mask_q[waddr] <= 1'b1;
  end

  // Combinational read and completeness flag.
  always_comb begin
    rdata = mem[raddr];
    full  = &mask_q;
  end

endmodule

// File: rtl/fsm_table_ctrl.sv
// Load/run controller for a table-driven FSM with a bounded step budget.
module fsm_table_ctrl
  import fsm_table_ctrl_pkg::*;
#(
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned ST_W      = DEF_ST_W,
  parameter int unsigned MAX_STEPS = 255,
  parameter int unsigned INIT_ST   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [IN_W+ST_W-1:0] wr_addr,
  input  logic [2*ST_W-1:0]    wr_data,
  input  logic                 wr_last,
  input  logic                 run_en,
  input  logic                 stop,
  input  logic [IN_W-1:0]      a,
  input  logic                 a_valid,
  output logic [ST_W-1:0]      saida,
  output logic                 out_valid,
  output logic [ST_W-1:0]      state_q,
  output logic                 busy,
  output logic                 err
);

  localparam logic [ST_W-1:0] InitSt   = ST_W'(INIT_ST);
  localparam logic [7:0]      MaxCount = 8'(MAX_STEPS);

  ctrl_e             ctrl_q, ctrl_d;
  logic [ST_W-1:0]   state_d, saida_d;
  logic              out_valid_d, err_d;
  logic [7:0]        count_q, count_d, count_inc;
  logic [2*ST_W-1:0] entry;
  logic              tbl_full, wr_fire;

  fsm_table_ram #(
    .AW(IN_W + ST_W),
    .DW(2 * ST_W)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (wr_fire),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr({a, state_q}),
    .rdata(entry),
    .full (tbl_full)
  );

  // Handshake and status decode.
  always_comb begin
    wr_ready  = (ctrl_q == CT_LOAD);
    wr_fire   = wr_valid & wr_ready;
    busy      = (ctrl_q == CT_LOAD) | (ctrl_q == CT_RUN);
    count_inc = count_q + 8'd1;
  end

  // Next-state logic for controller, FSM state, outputs and step budget.
  always_comb begin
    ctrl_d      = ctrl_q;
    state_d     = state_q;
    saida_d     = saida;
    out_valid_d = 1'b0;
    err_d       = err;
    count_d     = count_q;
    unique case (ctrl_q)
      CT_IDLE, CT_HALT: begin
        if (cfg_start) begin
          ctrl_d = CT_LOAD;
          err_d  = 1'b0;
        end else if (run_en) begin
          if (tbl_full) begin
            ctrl_d  = CT_RUN;
            state_d = InitSt;
            count_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CT_LOAD: begin
        if (wr_fire && wr_last) ctrl_d = CT_IDLE;
      end
      CT_RUN: begin
        // stop wins over a pending symbol; nothing is consumed that cycle.
        if (stop) begin
          ctrl_d = CT_HALT;
        end else if (a_valid) begin
          state_d     = entry[2*ST_W-1:ST_W];
          saida_d     = entry[ST_W-1:0];
          out_valid_d = 1'b1;
          count_d     = count_inc;
          if (count_inc == MaxCount) ctrl_d = CT_HALT;
        end
      end
      default: ctrl_d = CT_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= CT_IDLE;
      state_q   <= InitSt;
      saida     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      count_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      state_q   <= state_d;
      saida     <= saida_d;
      out_valid <= out_valid_d;
      err       <= err_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_fsm_table_ctrl.sv
// Scoreboard bench for fsm_table_ctrl: stimulus pushes expected steps, monitor pops on out_valid.
module tb_fsm_table_ctrl;

  localparam int unsigned IN_W = 2;
  localparam int unsigned ST_W = 3;
  localparam int unsigned MAX_STEPS = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cfg_start = 1'b0;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic [IN_W+ST_W-1:0] wr_addr = '0;
  logic [2*ST_W-1:0]    wr_data = '0;
  logic                 wr_last = 1'b0;
  logic                 run_en = 1'b0;
  logic                 stop = 1'b0;
  logic [IN_W-1:0]      a = '0;
  logic                 a_valid = 1'b0;
  logic [ST_W-1:0]      saida;
  logic                 out_valid;
  logic [ST_W-1:0]      state_q;
  logic                 busy;
  logic                 err;

  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q [$];  // {state_q, saida} expected per out_valid pulse

  fsm_table_ctrl #(
    .IN_W     (IN_W),
    .ST_W     (ST_W),
    .MAX_STEPS(MAX_STEPS),
    .INIT_ST  (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_start(cfg_start),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .run_en   (run_en),
    .stop     (stop),
    .a        (a),
    .a_valid  (a_valid),
    .saida    (saida),
    .out_valid(out_valid),
    .state_q  (state_q),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference table, hand-picked: a=0, s<3 cycles 0->1->2->0 emitting s;
  // everything else is next=(s+a+3)%8, out=a (gives addr31 = 6'o53).
  function automatic logic [5:0] ref_entry(input int addr);
    int s, av;
    logic [2:0] nx, ot;
    s  = addr % 8;
    av = addr / 8;
    if (av == 0 && s < 3) begin
      nx = 3'((s + 1) % 3);
      ot = 3'(s);
    end else begin
      nx = 3'((s + av + 3) % 8);
      ot = 3'(av);
    end
    return {nx, ot};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] sym, input logic push, input logic [5:0] exp);
    a = sym;
    a_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    a_valid = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_valid: got state=%0d saida=%0d, expected no pulse",
                 state_q, saida);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({state_q, saida} !== e) begin
          fails++;
          $display("FAIL step: got state=%0d saida=%0d, expected state=%0d saida=%0d",
                   state_q, saida, e[5:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int miss;
    // 1. Reset
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_state_q", 32'(state_q), 0);
    check("rst_saida", 32'(saida), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_valid", 32'(out_valid), 0);

    // 2. Run without a table
    tick();
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    check("norun_err", 32'(err), 1);
    check("norun_busy", 32'(busy), 0);
    step(2'd0, 1'b0, 6'd0);  // IDLE: must not produce out_valid

    // 3. Load the full reference table
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("load_busy", 32'(busy), 1);
    check("load_err_cleared", 32'(err), 0);
    miss = 0;
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 5'(i);
      wr_data  = ref_entry(i);
      wr_last  = (i == 31);
      if (wr_ready !== 1'b1) miss++;
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    check("burst_wr_ready_misses", 32'(miss), 0);
    check("post_load_wr_ready", 32'(wr_ready), 0);
    check("post_load_busy", 32'(busy), 0);

    // 3/4. Run with a=0 held; budget of 4 then HALT
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    check("run_busy", 32'(busy), 1);
    check("run_start_state", 32'(state_q), 0);
    step(2'd0, 1'b1, {3'd1, 3'd0});
    step(2'd0, 1'b1, {3'd2, 3'd1});
    step(2'd0, 1'b1, {3'd0, 3'd2});
    step(2'd0, 1'b1, {3'd1, 3'd0});
    step(2'd0, 1'b0, 6'd0);  // HALT: ignored
    step(2'd0, 1'b0, 6'd0);
    check("halt_busy", 32'(busy), 0);
    check("halt_state_frozen", 32'(state_q), 1);
    check("halt_saida_frozen", 32'(saida), 0);

    // Restart from INIT_ST
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    check("restart_state", 32'(state_q), 0);
    step(2'd0, 1'b1, {3'd1, 3'd0});

    // 5. stop beats a_valid
    stop = 1'b1;
    a_valid = 1'b1;
    a = 2'd0;
    tick();
    stop = 1'b0;
    a_valid = 1'b0;
    check("stop_state_hold", 32'(state_q), 1);
    check("stop_halt", 32'(busy), 0);

    // Rewrite addr0 -> next=2, out=0, then rerun
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 6'o20;
    wr_last  = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    check("rewrite_idle", 32'(busy), 0);
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    step(2'd0, 1'b1, {3'd2, 3'd0});
    check("rewrite_state", 32'(state_q), 2);

    // 6. Reset mid-LOAD
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 5'(i);
      wr_data  = ref_entry(i);
      tick();
    end
    reset = 1'b0;
    #1;
    check("midload_rst_busy", 32'(busy), 0);
    check("midload_rst_wr_ready", 32'(wr_ready), 0);
    check("midload_rst_state", 32'(state_q), 0);
    wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    check("mask_cleared_err", 32'(err), 1);
    check("mask_cleared_idle", 32'(busy), 0);
    step(2'd0, 1'b0, 6'd0);
    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
